cam_bram_mm: RTL and testbench
==============================

# cam_bram_mm

Parametrised block-RAM content-addressable memory with multi-match output, a pipelined compare port, and a valid/ready write port. Each write atomically replaces the entry at its address, including removal of the old key, and deletes go through the same port. Entry-valid tracking and an occupancy count are maintained. The block sits behind the lookup/classification logic as the associative store for address and tag matching.

## Interface
- DATA_WIDTH, 64, search key width
- ADDR_WIDTH, 5, log2 of entry count; RAM_DEPTH = 2**ADDR_WIDTH
- SLICE_WIDTH, 9, key bits per slice RAM; SLICE_COUNT = ceil(DATA_WIDTH/SLICE_WIDTH); last slice width W_last = DATA_WIDTH - SLICE_WIDTH*(SLICE_COUNT-1)
- LSB_PRIORITY, 1, 1: lowest matching index wins; 0: highest wins

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- write_addr  in  ADDR_WIDTH  target entry
- write_data  in  DATA_WIDTH  key to store (ignored on delete)
- write_delete  in  1  1 = delete entry at write_addr
- write_valid  in  1  write request
- write_ready  out  1  block can accept a request
- compare_data  in  DATA_WIDTH  search key
- compare_valid  in  1  search request
- match_valid  out  1  result strobe, 2 cycles after compare_valid
- match  out  1  at least one entry matched
- match_addr  out  ADDR_WIDTH  priority-encoded matching entry
- match_many  out  RAM_DEPTH  one bit per matching entry
- entry_valid  out  RAM_DEPTH  occupancy bitmap
- entry_count  out  ADDR_WIDTH+1  number of valid entries, 0..RAM_DEPTH

## Operation
- Storage:
  - SLICE_COUNT dual-port RAMs, each with depth 2**slice width and width RAM_DEPTH; bit i at address k means entry i holds k in that slice.
  - A shadow RAM of RAM_DEPTH x DATA_WIDTH holds the stored key of each entry.
  - entry_valid is held in registers.
- FSM states: INIT, IDLE, CLR_RD, CLR_WR, SET_RD, SET_WR.
- INIT:
  - Counter runs from 2**SLICE_WIDTH-1 down to 0 and writes zero to every slice address. The address is masked to the slice width.
  - When the counter reaches 0, the FSM goes to IDLE.
- IDLE:
  - write_ready = 1.
  - On write_valid && write_ready, latch addr, data and delete, then go to CLR_RD.
- CLR_RD: read the shadow RAM at the latched address; read the slice words at the old key.
- CLR_WR:
  - If entry_valid[addr] is set, write each slice word with bit addr cleared.
  - On a delete, go to IDLE and clear entry_valid[addr]. Otherwise go to SET_RD.
- SET_RD: read the slice words at the new key.
- SET_WR:
  - Write each slice word with bit addr set.
  - Write the shadow RAM and set entry_valid[addr].
  - Go to IDLE.
- Delete of an invalid entry: no slice RAM write, count unchanged, 2 busy cycles.
- Rewrite of a valid entry with the same key: clear then set, so the net content is unchanged.
- entry_count:
  - +1 when SET_WR targets an invalid entry.
  - -1 when a delete's CLR_WR targets a valid entry.
  - Unchanged otherwise; it never wraps.
- Compare path:
  - Slice RAMs are read on port A.
  - The per-slice words are ANDed to form match_many.
  - A priority encoder, per LSB_PRIORITY, produces match and match_addr.
  - Key padding bits above DATA_WIDTH are zero.
- Duplicate keys at several entries are legal: every such bit is set in match_many, and match_addr follows priority.

## Timing
- Reset values:
  - state = INIT, write_ready = 0, match_valid = 0, match = 0, match_addr = 0, match_many = 0, entry_valid = 0, entry_count = 0.
  - The compare pipeline is flushed.
- INIT takes 2**SLICE_WIDTH cycles (512 at default). write_ready rises on the cycle after the counter-0 write.
- Write latency: write_ready is low for 4 cycles after acceptance. The next request can be accepted on cycle 5.
- Delete latency: write_ready is low for 2 cycles.
- Compare:
  - Fully pipelined, one per cycle, no backpressure.
  - compare_valid at cycle T gives registered results with match_valid = 1 at T+2.
  - The outputs hold their last value while match_valid = 0.
- Compare vs. write collision:
  - A compare in the same cycle as CLR_WR or SET_WR reads the pre-write contents (read-before-write).
  - Results reflect the new entry for compares issued from the cycle after SET_WR.
- write_valid while write_ready = 0: the request is ignored, not queued. The requester holds write_valid until the handshake.
- rst asserted in any state, including mid-write:
  - Aborts the operation and returns to INIT, re-clearing all entries.
  - match_valid = 0 on the next cycle.

## Test plan
- Reset then idle: write_ready is 0 for 512 cycles, then 1. A compare of 0x0 gives match_valid = 1, match = 0, match_many = 0.
- Write key 0x1234 at addr 3, then compare 0x1234: two cycles later match = 1, match_addr = 3, match_many = 0x8, entry_count = 1.
- Write 0xABCD at addrs 3 and 7, then compare: match_many = 0x88. match_addr = 3 with LSB_PRIORITY = 1 and 7 with LSB_PRIORITY = 0. entry_count = 2.
- Overwrite addr 3 (holding 0x1234) with 0x5555: compare 0x1234 gives match = 0; compare 0x5555 gives match_addr = 3; entry_count is unchanged.
- Delete addr 3: write_ready is low for 2 cycles, entry_valid[3] = 0, entry_count is decremented, compare gives match = 0. Deleting addr 3 again leaves the count unchanged.
- Stream compares on 8 consecutive cycles during a write: 8 back-to-back match_valid pulses in order, with pre- and post-write results split at the SET_WR boundary. Asserting rst during SET_RD gives INIT, entry_count = 0, and all subsequent compares miss.

Source files
------------

// File: rtl/cam_bram_mm.sv
// Block-RAM CAM: key split into slices, each slice RAM holds a one-hot entry bitmap per key value.
// Compare ANDs the slice bitmaps; writes clear the old key's bits then set the new key's bits.
module cam_bram_mm #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 5,
  parameter int SLICE_WIDTH  = 9,
  parameter bit LSB_PRIORITY = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      write_addr,
  input  logic [DATA_WIDTH-1:0]      write_data,
  input  logic                       write_delete,
  input  logic                       write_valid,
  output logic                       write_ready,
  input  logic [DATA_WIDTH-1:0]      compare_data,
  input  logic                       compare_valid,
  output logic                       match_valid,
  output logic                       match,
  output logic [ADDR_WIDTH-1:0]      match_addr,
  output logic [2**ADDR_WIDTH-1:0]   match_many,
  output logic [2**ADDR_WIDTH-1:0]   entry_valid,
  output logic [ADDR_WIDTH:0]        entry_count
);
  localparam int RAM_DEPTH   = 2**ADDR_WIDTH;
  localparam int SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
  localparam int W_LAST      = DATA_WIDTH - SLICE_WIDTH*(SLICE_COUNT-1);
  localparam int STAGES      = 1;

  typedef enum logic [2:0] {INIT, IDLE, CLR_RD, CLR_WR, SET_RD, SET_WR} state_t;

  state_t                             state, state_nx;
  logic [SLICE_WIDTH-1:0]             init_cnt;
  logic [ADDR_WIDTH-1:0]              wr_addr;
  logic [DATA_WIDTH-1:0]              wr_data;
  logic                               wr_del;
  logic [DATA_WIDTH-1:0]              shadow [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]              old_key;
  logic [RAM_DEPTH-1:0]               wr_bit;
  logic                               slice_we, ram_zero, ram_set, use_new;
  logic [SLICE_COUNT-1:0][RAM_DEPTH-1:0] rd_a;
  logic [RAM_DEPTH-1:0]               hit_vec;
  logic [ADDR_WIDTH-1:0]              hit_addr;
  logic [STAGES:0]                    vld_pipe;

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      INIT:    if (init_cnt == '0) state_nx = IDLE;
      IDLE:    if (write_valid) state_nx = CLR_RD;
      CLR_RD:  state_nx = CLR_WR;
      CLR_WR:  state_nx = wr_del ? IDLE : SET_RD;
      SET_RD:  state_nx = SET_WR;
      SET_WR:  state_nx = IDLE;
      default: state_nx = INIT;
    endcase
  end

  always_comb begin
    write_ready = 1'b0;
    slice_we    = 1'b0;
    ram_zero    = 1'b0;
    ram_set     = 1'b0;
    use_new     = 1'b0;
    case (state)
      INIT:   begin slice_we = 1'b1; ram_zero = 1'b1; end
      IDLE:   write_ready = 1'b1;
      CLR_WR: slice_we = entry_valid[wr_addr];
      SET_RD: use_new = 1'b1;
      SET_WR: begin slice_we = 1'b1; ram_set = 1'b1; use_new = 1'b1; end
      default: ;
    endcase
  end

  // ---------------- write datapath ----------------
  always_ff @(posedge clk) begin
    if (state == IDLE && write_valid) begin
      wr_addr <= write_addr;
      wr_data <= write_data;
      wr_del  <= write_delete;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt    <= '1;
      entry_valid <= '0;
      entry_count <= '0;
    end else begin
      if (state == INIT) init_cnt <= init_cnt - SLICE_WIDTH'(1);
      if (state == CLR_WR && wr_del && entry_valid[wr_addr]) begin
        entry_valid[wr_addr] <= 1'b0;
        entry_count          <= entry_count - (ADDR_WIDTH+1)'(1);
      end
      if (state == SET_WR) begin
        entry_valid[wr_addr] <= 1'b1;
        if (!entry_valid[wr_addr]) entry_count <= entry_count + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Shadow is read combinationally so the old key is ready to address the slices in CLR_RD.
  always_ff @(posedge clk) begin
    if (!rst && state == SET_WR) shadow[wr_addr] <= wr_data;
  end
  assign old_key = shadow[wr_addr];
  assign wr_bit  = {{(RAM_DEPTH-1){1'b0}}, 1'b1} << wr_addr;

  // ---------------- slice RAMs: port A compare, port B read-modify-write ----------------
  for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_slice
    localparam int SW = (s == SLICE_COUNT-1) ? W_LAST : SLICE_WIDTH;
    logic [RAM_DEPTH-1:0] mem [2**SW];
    logic [RAM_DEPTH-1:0] q_a, q_b, wdat;
    logic [SW-1:0]        addr_a, addr_b;

    assign addr_a = compare_data[s*SLICE_WIDTH +: SW];
    assign addr_b = ram_zero ? init_cnt[SW-1:0]
                  : use_new  ? wr_data[s*SLICE_WIDTH +: SW]
                  :            old_key[s*SLICE_WIDTH +: SW];
    assign wdat   = ram_zero ? '0 : ram_set ? (q_b | wr_bit) : (q_b & ~wr_bit);

    always_ff @(posedge clk) begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
      if (slice_we && !rst) mem[addr_b] <= wdat;
    end
    assign rd_a[s] = q_a;
  end

  // ---------------- compare pipeline ----------------
  always_comb begin
    hit_vec = '1;
    for (int s = 0; s < SLICE_COUNT; s++) hit_vec &= rd_a[s];
  end

  always_comb begin
    hit_addr = '0;
    if (LSB_PRIORITY) begin
      for (int i = RAM_DEPTH-1; i >= 0; i--) if (hit_vec[i]) hit_addr = ADDR_WIDTH'(i);
    end else begin
      for (int i = 0; i < RAM_DEPTH; i++) if (hit_vec[i]) hit_addr = ADDR_WIDTH'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      match      <= 1'b0;
      match_addr <= '0;
      match_many <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], compare_valid};
      if (vld_pipe[0]) begin
        match_many <= hit_vec;
        match      <= |hit_vec;
        match_addr <= hit_addr;
      end
    end
  end
  assign match_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_cam_bram_mm.sv
// Bench for cam_bram_mm: directed scenarios plus random traffic against an entry-table model
// that tracks when each write becomes visible to compares.
module tb_cam_bram_mm;
  localparam int DW = 64, AW = 5, SW = 9, DEPTH = 32;
  localparam bit LSB = 1'b1;
  localparam int INIT_CYC = 512;

  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] write_data = '0, compare_data = '0;
  logic write_delete = 1'b0, write_valid = 1'b0, compare_valid = 1'b0;
  logic write_ready, match_valid, match;
  logic [AW-1:0] match_addr;
  logic [DEPTH-1:0] match_many, entry_valid;
  logic [AW:0] entry_count;

  cam_bram_mm #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW), .LSB_PRIORITY(LSB)) dut (
    .clk(clk), .rst(rst),
    .write_addr(write_addr), .write_data(write_data), .write_delete(write_delete),
    .write_valid(write_valid), .write_ready(write_ready),
    .compare_data(compare_data), .compare_valid(compare_valid),
    .match_valid(match_valid), .match(match), .match_addr(match_addr),
    .match_many(match_many), .entry_valid(entry_valid), .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic m; logic [AW-1:0] a; logic [DEPTH-1:0] many; } exp_t;
  exp_t eq[$];
  exp_t last;
  logic obs[$];

  logic          m_valid [DEPTH];
  logic          m_hid   [DEPTH];   // overwrite in flight: old key cleared, new not yet set
  logic [DW-1:0] m_key   [DEPTH];
  int cyc = 0, ready_at = 0, busy_until = 0, rm_e = -1, add_e = -1;
  logic [AW-1:0] p_a;
  logic [DW-1:0] p_d;
  logic          p_del;
  int checks = 0, errors = 0;
  logic [DW-1:0] pool [4];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic model_ready();
    return (cyc >= ready_at) && (cyc >= busy_until);
  endfunction

  function automatic exp_t model_cmp(input logic [DW-1:0] k, input int due);
    exp_t e;
    bit found = 1'b0;
    e.due = due; e.many = '0; e.a = '0;
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && !m_hid[i] && m_key[i] == k) e.many[i] = 1'b1;
    e.m = |e.many;
    for (int i = 0; i < DEPTH; i++) begin
      int j = LSB ? i : DEPTH-1-i;
      if (!found && e.many[j]) begin e.a = AW'(j); found = 1'b1; end
    end
    return e;
  endfunction

  task automatic apply_events();
    if (rm_e >= 0 && cyc >= rm_e) begin
      if (p_del) m_valid[p_a] = 1'b0;
      else if (m_valid[p_a]) m_hid[p_a] = 1'b1;
      rm_e = -1;
    end
    if (add_e >= 0 && cyc >= add_e) begin
      m_valid[p_a] = 1'b1; m_hid[p_a] = 1'b0; m_key[p_a] = p_d; add_e = -1;
    end
  endtask

  task automatic check_outputs();
    logic [DEPTH-1:0] bm;
    int n;
    exp_t e;
    bm = '0; n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) begin bm[i] = 1'b1; n++; end
    chk("write_ready", 64'(write_ready), 64'(model_ready()));
    chk("entry_valid", 64'(entry_valid), 64'(bm));
    chk("entry_count", 64'(entry_count), 64'(n));
    if (eq.size() > 0 && eq[0].due == cyc) begin
      e = eq.pop_front();
      chk("match_valid", 64'(match_valid), 64'(1));
      chk("match", 64'(match), 64'(e.m));
      chk("match_many", 64'(match_many), 64'(e.many));
      if (e.m) chk("match_addr", 64'(match_addr), 64'(e.a));
      obs.push_back(match);
      last = e;
    end else begin
      chk("match_valid_idle", 64'(match_valid), 64'(0));
      chk("hold_match", 64'(match), 64'(last.m));
      chk("hold_many", 64'(match_many), 64'(last.many));
      if (last.m) chk("hold_addr", 64'(match_addr), 64'(last.a));
    end
  endtask

  task automatic step(input logic cv, input logic [DW-1:0] cd, input logic wv,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic del);
    compare_valid = cv; compare_data = cd;
    write_valid = wv; write_addr = wa; write_data = wd; write_delete = del;
    if (cv) eq.push_back(model_cmp(cd, cyc + 2));
    if (wv && model_ready()) begin
      p_a = wa; p_d = wd; p_del = del;
      rm_e = cyc + 3;
      add_e = del ? -1 : cyc + 5;
      busy_until = cyc + (del ? 3 : 5);
    end
    @(negedge clk); cyc++;
    apply_events();
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic cmp(input logic [DW-1:0] k);
    step(1'b1, k, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic wait_idle();
    while (!model_ready()) idle();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic del);
    wait_idle();
    step(1'b0, '0, 1'b1, a, d, del);
  endtask

  task automatic busy_len(input string tag, input int exp);
    int lo = 0;
    while (!write_ready && lo < 20) begin lo++; idle(); end
    chk(tag, 64'(lo), 64'(exp));
  endtask

  task automatic do_reset();
    int n = 0;
    rst = 1'b1; compare_valid = 1'b0; write_valid = 1'b0;
    @(negedge clk); cyc++;
    for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 1'b0; m_hid[i] = 1'b0; m_key[i] = '0; end
    eq.delete();
    rm_e = -1; add_e = -1; busy_until = 0;
    last.due = 0; last.m = 1'b0; last.a = '0; last.many = '0;
    ready_at = cyc + INIT_CYC;
    chk("rst_match_valid", 64'(match_valid), 64'(0));
    chk("rst_match", 64'(match), 64'(0));
    chk("rst_match_addr", 64'(match_addr), 64'(0));
    chk("rst_match_many", 64'(match_many), 64'(0));
    chk("rst_entry_valid", 64'(entry_valid), 64'(0));
    chk("rst_entry_count", 64'(entry_count), 64'(0));
    chk("rst_write_ready", 64'(write_ready), 64'(0));
    rst = 1'b0;
    while (!write_ready && n < 2*INIT_CYC) begin n++; idle(); end
    chk("init_cycles", 64'(n), 64'(INIT_CYC));
  endtask

  initial begin
    logic [7:0] v;
    pool[0] = 64'h0000_0000_0000_0001;
    pool[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    pool[2] = 64'h8000_0000_0000_0000;
    pool[3] = 64'h0123_4567_89AB_CDEF;

    do_reset();

    // empty table
    cmp(64'h0); idle(); idle();
    chk("t1_match", 64'(match), 64'(0));

    // single write
    wr(5'd3, 64'h1234, 1'b0);
    busy_len("write_busy", 4);
    cmp(64'h1234); idle();
    chk("t2_addr", 64'(match_addr), 64'(3));
    chk("t2_many", 64'(match_many), 64'h8);
    chk("t2_count", 64'(entry_count), 64'(1));

    // duplicate keys
    wr(5'd3, 64'hABCD, 1'b0);
    wr(5'd7, 64'hABCD, 1'b0);
    wait_idle();
    cmp(64'hABCD); idle();
    chk("t3_many", 64'(match_many), 64'h88);
    chk("t3_addr", 64'(match_addr), 64'(LSB ? 3 : 7));
    chk("t3_count", 64'(entry_count), 64'(2));

    // overwrite removes old key
    wr(5'd3, 64'h1234, 1'b0);
    wr(5'd3, 64'h5555, 1'b0);
    wait_idle();
    cmp(64'h1234); idle();
    chk("t4_old_miss", 64'(match), 64'(0));
    cmp(64'h5555); idle();
    chk("t4_new_addr", 64'(match_addr), 64'(3));
    chk("t4_count", 64'(entry_count), 64'(2));

    // delete, then delete again
    wr(5'd3, '0, 1'b1);
    busy_len("delete_busy", 2);
    chk("t5_valid3", 64'(entry_valid[3]), 64'(0));
    chk("t5_count", 64'(entry_count), 64'(1));
    cmp(64'h5555); idle();
    chk("t5_miss", 64'(match), 64'(0));
    wr(5'd3, '0, 1'b1);
    wait_idle();
    chk("t5_count_again", 64'(entry_count), 64'(1));

    // same-key rewrite keeps contents
    wr(5'd7, 64'hABCD, 1'b0);
    wait_idle();
    cmp(64'hABCD); idle();
    chk("t6_many", 64'(match_many), 64'h80);

    // compare stream across a write: first five see old contents, last three the new entry
    wait_idle();
    obs.delete();
    step(1'b1, 64'hDEAD_BEEF_0000_0010, 1'b1, 5'd10, 64'hDEAD_BEEF_0000_0010, 1'b0);
    for (int i = 0; i < 7; i++) cmp(64'hDEAD_BEEF_0000_0010);
    idle(); idle(); idle();
    v = '0;
    for (int i = 0; i < 8 && i < obs.size(); i++) v[i] = obs[i];
    chk("stream_pulses", 64'(obs.size()), 64'(8));
    chk("stream_split", 64'(v), 64'he0);

    // random traffic
    for (int t = 0; t < 1500; t++) begin
      logic cv, wv, del;
      logic [DW-1:0] ck, wd;
      cv  = 1'($urandom_range(0, 1));
      ck  = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} : pool[$urandom_range(0, 3)];
      wv  = ($urandom_range(0, 2) == 0);
      del = ($urandom_range(0, 3) == 0);
      wd  = pool[$urandom_range(0, 3)];
      step(cv, ck, wv, AW'($urandom_range(0, DEPTH-1)), wd, del);
    end

    // reset during SET_RD
    wait_idle();
    wr(5'd4, pool[0], 1'b0);
    idle(); idle();
    do_reset();
    chk("post_rst_count", 64'(entry_count), 64'(0));
    for (int i = 0; i < 4; i++) cmp(pool[i]);
    cmp(64'hABCD); cmp(64'h5555);
    idle(); idle(); idle();
    chk("post_rst_miss", 64'(match), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
